// File: rtl/fetch_cur_chroma_load_pkg.sv
// Shared definitions for the current-LCU chroma loader: FSM encodings and geometry.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package fetch_cur_chroma_load_pkg;

    // Loader FSM encodings.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // U plane (32 rows) followed by V plane (32 rows).
    localparam int CHROMA_WORDS   = 64;
    // Four 8-pixel beats make one 32-pixel row word.
    localparam int BEATS_PER_WORD = 4;
    localparam int ROW_PIX        = 32;

    localparam logic [5:0] LAST_WORD = 6'(CHROMA_WORDS - 1);

endpackage

// File: rtl/fetch_chroma_pack.sv
// Packs 8-pixel external beats into 32-pixel row words, first beat in the MSBs.
// Latency: completed word is presented one cycle after its fourth beat is accepted.
// Backpressure: none; every beat_vld_i is consumed. clr_i drops any partial word and a pending write.
// Ports: clk/rstn, clr_i (sync clear), beat_vld_i/beat_dat_i (beat in),
//        word_vld_o/word_dat_o (one-cycle word strobe; data holds between strobes).
module fetch_chroma_pack
    import fetch_cur_chroma_load_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int BEAT_PIX    = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clr_i,
    input  logic                              beat_vld_i,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0]   beat_dat_i,
    output logic                              word_vld_o,
    output logic [ROW_PIX*PIXEL_WIDTH-1:0]    word_dat_o
);

    localparam int BEAT_W = BEAT_PIX * PIXEL_WIDTH;
    localparam int ROW_W  = ROW_PIX * PIXEL_WIDTH;

    logic [ROW_W-1:0] pack_q, pack_d;
    logic [ROW_W-1:0] word_q, word_d;
    logic [ROW_W-1:0] filled;
    logic [1:0]       bcnt_q, bcnt_d;
    logic             word_vld_q, word_vld_d;

    // Beat k lands in slot k counted down from the MSB end, so pixel order
    // within the row is preserved regardless of gaps between beats.
    always_comb begin
        filled = pack_q;
        filled[(ROW_W - BEAT_W) - int'(bcnt_q) * BEAT_W +: BEAT_W] = beat_dat_i;
    end

    always_comb begin
        pack_d     = pack_q;
        bcnt_d     = bcnt_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        if (clr_i) begin
            pack_d = '0;
            bcnt_d = '0;
        end else if (beat_vld_i) begin
            pack_d = filled;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'(BEATS_PER_WORD - 1)) begin
                word_d     = filled;
                word_vld_d = 1'b1;
                pack_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_q     <= '0;
            bcnt_q     <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            bcnt_q     <= bcnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign word_vld_o = word_vld_q;
    assign word_dat_o = word_q;

endmodule

// File: rtl/fetch_cur_chroma_load.sv
// Current-LCU chroma loader: requests one LCU's U+V chroma and writes 64 packed row words.
// Latency: each row word is written one cycle after its 4th beat; done one cycle after word 63.
// Backpressure: none while loading (ready held high); ready drops once the 256th beat is in.
// Ports: sysif_* (start pulse, LCU x/y), ext_req_* (level request until ack),
//        ext_data_* (beat stream), ext_load_* (word write stream, done pulse), busy_o, overrun_o.
// Optional: FETCH_CUR_CHROMA_LOAD_PERF_EN adds load_cycles_o (REQ+LOAD cycle count, saturating).
module fetch_cur_chroma_load
    import fetch_cur_chroma_load_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int BEAT_PIX    = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              sysif_start_i,
    input  logic [7:0]                        sysif_lcu_x_i,
    input  logic [7:0]                        sysif_lcu_y_i,
    output logic                              ext_req_o,
    output logic [7:0]                        ext_req_x_o,
    output logic [7:0]                        ext_req_y_o,
    input  logic                              ext_req_ack_i,
    input  logic                              ext_data_valid_i,
    input  logic [BEAT_PIX*PIXEL_WIDTH-1:0]   ext_data_i,
    output logic                              ext_data_ready_o,
    output logic                              ext_load_valid_o,
    output logic [5:0]                        ext_load_addr_o,
    output logic [ROW_PIX*PIXEL_WIDTH-1:0]    ext_load_data_o,
    output logic                              ext_load_done_o,
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
    output logic [15:0]                       load_cycles_o,
`endif
    output logic                              busy_o,
    output logic                              overrun_o
);

    state_e     state_q, state_d;
    logic [5:0] wcnt_q, wcnt_d;
    logic [7:0] req_x_q, req_x_d;
    logic [7:0] req_y_q, req_y_d;
    logic       overrun_q, overrun_d;

    logic       beat_acc;
    logic       word_vld;
    logic       last_wr;

    // A start in any non-idle state restarts the load from scratch, so the
    // packer is cleared on every start.
    fetch_chroma_pack #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .BEAT_PIX    (BEAT_PIX)
    ) u_pack (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (sysif_start_i),
        .beat_vld_i (beat_acc),
        .beat_dat_i (ext_data_i),
        .word_vld_o (word_vld),
        .word_dat_o (ext_load_data_o)
    );

    assign beat_acc = ext_data_valid_i && ext_data_ready_o;
    // Word 63 is on the write port this cycle; all 256 beats are already in.
    assign last_wr  = word_vld && (wcnt_q == LAST_WORD);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (sysif_start_i) begin
            state_d = ST_REQ;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_REQ:  if (ext_req_ack_i) state_d = ST_LOAD;
                ST_LOAD: if (last_wr) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        ext_req_o        = (state_q == ST_REQ);
        ext_data_ready_o = (state_q == ST_LOAD) && !last_wr;
        ext_load_done_o  = (state_q == ST_DONE);
        busy_o           = (state_q == ST_REQ) || (state_q == ST_LOAD);
    end

    // Word counter, request coordinates, sticky overrun.
    always_comb begin
        wcnt_d    = wcnt_q;
        req_x_d   = req_x_q;
        req_y_d   = req_y_q;
        overrun_d = overrun_q;
        if (sysif_start_i) begin
            wcnt_d  = '0;
            req_x_d = sysif_lcu_x_i;
            req_y_d = sysif_lcu_y_i;
            if (state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
        end else if (word_vld) begin
            wcnt_d = wcnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcnt_q    <= '0;
            req_x_q   <= '0;
            req_y_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wcnt_q    <= wcnt_d;
            req_x_q   <= req_x_d;
            req_y_q   <= req_y_d;
            overrun_q <= overrun_d;
        end
    end

    assign ext_req_x_o      = req_x_q;
    assign ext_req_y_o      = req_y_q;
    assign ext_load_valid_o = word_vld;
    assign ext_load_addr_o  = wcnt_q;
    assign overrun_o        = overrun_q;

`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
    logic [15:0] cyc_q, cyc_d;

    // Cleared as REQ is entered, counts each REQ/LOAD cycle, and holds
    // through DONE/IDLE so the last load's figure stays readable.
    always_comb begin
        cyc_d = cyc_q;
        if (sysif_start_i) begin
            cyc_d = '0;
        end else if (busy_o && (cyc_q != 16'hFFFF)) begin
            cyc_d = cyc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign load_cycles_o = cyc_q;
`endif

endmodule

// File: tb/tb_fetch_cur_chroma_load.sv
// Directed bench for fetch_cur_chroma_load: reset, nominal, gapped, overrun, mid-load reset.
module tb_fetch_cur_chroma_load;

    localparam int PW = 8;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic           sysif_start_i = 1'b0;
    logic [7:0]     sysif_lcu_x_i = '0;
    logic [7:0]     sysif_lcu_y_i = '0;
    logic           ext_req_o;
    logic [7:0]     ext_req_x_o;
    logic [7:0]     ext_req_y_o;
    logic           ext_req_ack_i = 1'b0;
    logic           ext_data_valid_i = 1'b0;
    logic [8*PW-1:0] ext_data_i = '0;
    logic           ext_data_ready_o;
    logic           ext_load_valid_o;
    logic [5:0]     ext_load_addr_o;
    logic [32*PW-1:0] ext_load_data_o;
    logic           ext_load_done_o;
    logic           busy_o;
    logic           overrun_o;
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
    logic [15:0]    load_cycles_o;
`endif

    fetch_cur_chroma_load #(.PIXEL_WIDTH(PW), .BEAT_PIX(8)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .sysif_start_i    (sysif_start_i),
        .sysif_lcu_x_i    (sysif_lcu_x_i),
        .sysif_lcu_y_i    (sysif_lcu_y_i),
        .ext_req_o        (ext_req_o),
        .ext_req_x_o      (ext_req_x_o),
        .ext_req_y_o      (ext_req_y_o),
        .ext_req_ack_i    (ext_req_ack_i),
        .ext_data_valid_i (ext_data_valid_i),
        .ext_data_i       (ext_data_i),
        .ext_data_ready_o (ext_data_ready_o),
        .ext_load_valid_o (ext_load_valid_o),
        .ext_load_addr_o  (ext_load_addr_o),
        .ext_load_data_o  (ext_load_data_o),
        .ext_load_done_o  (ext_load_done_o),
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
        .load_cycles_o    (load_cycles_o),
`endif
        .busy_o           (busy_o),
        .overrun_o        (overrun_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Write/done monitor, sampled on the falling edge.
    logic [5:0]       wr_addr[$];
    logic [32*PW-1:0] wr_dat[$];
    int               wr_cyc[$];
    int               done_cnt = 0;
    int               done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (ext_load_valid_o) begin
                wr_addr.push_back(ext_load_addr_o);
                wr_dat.push_back(ext_load_data_o);
                wr_cyc.push_back(cyc);
            end
            if (ext_load_done_o) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pixel p of the LCU chroma stream carries the value p (mod 256).
    function automatic logic [8*PW-1:0] beat_of(input int j);
        logic [8*PW-1:0] d;
        for (int i = 0; i < 8; i++) d[(7 - i) * PW +: PW] = 8'(8 * j + i);
        return d;
    endfunction

    function automatic logic [32*PW-1:0] exp_word(input int n);
        logic [32*PW-1:0] w;
        for (int i = 0; i < 32; i++) w[(31 - i) * PW +: PW] = 8'(32 * n + i);
        return w;
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_dat.delete();
        wr_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] x, input logic [7:0] y);
        sysif_lcu_x_i = x;
        sysif_lcu_y_i = y;
        sysif_start_i = 1'b1;
        tick();
        sysif_start_i = 1'b0;
    endtask

    // Two REQ cycles: ack is raised in the second one.
    task automatic ack_after2();
        tick();
        ext_req_ack_i = 1'b1;
        tick();
        ext_req_ack_i = 1'b0;
    endtask

    task automatic feed(input int n, input bit gapped, output int notrdy);
        notrdy = 0;
        for (int j = 0; j < n; j++) begin
            if (gapped) begin
                for (int g = 0; g < 3 && $urandom_range(0, 2) != 0; g++) begin
                    ext_data_valid_i = 1'b0;
                    tick();
                end
            end
            ext_data_valid_i = 1'b1;
            ext_data_i = beat_of(j);
            if (!ext_data_ready_o) notrdy++;
            tick();
        end
        ext_data_valid_i = 1'b0;
    endtask

    // Offer extra beats past the 256th, then wait (bounded) for done.
    task automatic finish_load();
        ext_data_valid_i = 1'b1;
        ext_data_i = 64'hDEAD_BEEF_CAFE_F00D;
        repeat (3) tick();
        ext_data_valid_i = 1'b0;
        for (int k = 0; k < 20 && done_cnt == 0; k++) tick();
    endtask

    task automatic check_full(input string tag, input bit spacing);
        int bad_addr, bad_dat, bad_gap, n;
        bad_addr = 0; bad_dat = 0; bad_gap = 0;
        n = (wr_addr.size() < 64) ? wr_addr.size() : 64;
        chk({tag, "_wr_count"}, wr_addr.size(), 64);
        for (int i = 0; i < n; i++) begin
            if (wr_addr[i] !== 6'(i)) bad_addr++;
            if (wr_dat[i] !== exp_word(i)) bad_dat++;
            if (spacing && i > 0 && (wr_cyc[i] - wr_cyc[i-1]) != 4) bad_gap++;
        end
        chk({tag, "_addr_seq_bad"}, bad_addr, 0);
        chk({tag, "_data_bad"}, bad_dat, 0);
        if (spacing) chk({tag, "_write_spacing_bad"}, bad_gap, 0);
        if (n == 64) begin
            chk({tag, "_addr32_v_row0"}, wr_dat[32], exp_word(32));
            chk({tag, "_done_after_last"}, done_cyc, wr_cyc[63] + 1);
        end
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_busy_after"}, busy_o, 1'b0);
        chk({tag, "_ready_after"}, ext_data_ready_o, 1'b0);
        chk({tag, "_data_hold"}, ext_load_data_o, exp_word(63));
    endtask

    initial begin
        int nr;

        // Reset state.
        rstn = 1'b0;
        repeat (2) tick();
        chk("rst_req", ext_req_o, 1'b0);
        chk("rst_req_x", ext_req_x_o, 8'd0);
        chk("rst_req_y", ext_req_y_o, 8'd0);
        chk("rst_ready", ext_data_ready_o, 1'b0);
        chk("rst_load_valid", ext_load_valid_o, 1'b0);
        chk("rst_addr", ext_load_addr_o, 6'd0);
        chk("rst_data", ext_load_data_o, '0);
        chk("rst_done", ext_load_done_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_overrun", overrun_o, 1'b0);
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
        chk("rst_perf", load_cycles_o, 16'd0);
`endif
        #3 rstn = 1'b1;
        tick();

        // Beats offered while idle are ignored.
        ext_data_valid_i = 1'b1;
        ext_data_i = beat_of(5);
        repeat (3) tick();
        ext_data_valid_i = 1'b0;
        tick();
        chk("idle_no_writes", wr_addr.size(), 0);

        // Nominal load, back-to-back beats.
        clear_mon();
        do_start(8'd3, 8'd5);
        chk("nom_req_hi", ext_req_o, 1'b1);
        chk("nom_req_x", ext_req_x_o, 8'd3);
        chk("nom_req_y", ext_req_y_o, 8'd5);
        chk("nom_busy", busy_o, 1'b1);
        ack_after2();
        chk("nom_req_fall", ext_req_o, 1'b0);
        chk("nom_ready", ext_data_ready_o, 1'b1);
        feed(256, 1'b0, nr);
        chk("nom_not_ready", nr, 0);
        finish_load();
        check_full("nom", 1'b1);
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
        chk("nom_perf", load_cycles_o, 16'd259);
        repeat (3) tick();
        chk("nom_perf_held", load_cycles_o, 16'd259);
`endif
        chk("nom_overrun", overrun_o, 1'b0);

        // Gapped valid.
        clear_mon();
        do_start(8'd7, 8'd9);
        ack_after2();
        feed(256, 1'b1, nr);
        chk("gap_not_ready", nr, 0);
        finish_load();
        check_full("gap", 1'b0);

        // Overrun: restart after 100 beats.
        clear_mon();
        do_start(8'd1, 8'd2);
        ack_after2();
        feed(100, 1'b0, nr);
        do_start(8'd10, 8'd11);
        chk("ovr_first_writes", wr_addr.size(), 25);
        chk("ovr_sticky_set", overrun_o, 1'b1);
        chk("ovr_new_req", ext_req_o, 1'b1);
        chk("ovr_req_x", ext_req_x_o, 8'd10);
        chk("ovr_req_y", ext_req_y_o, 8'd11);
        chk("ovr_no_done_first", done_cnt, 0);
        clear_mon();
        ack_after2();
        feed(256, 1'b0, nr);
        finish_load();
        check_full("ovr", 1'b1);
        chk("ovr_still_set", overrun_o, 1'b1);

        // Reset in the middle of a load (word 19 on the write port).
        clear_mon();
        do_start(8'd4, 8'd6);
        ack_after2();
        feed(80, 1'b0, nr);
        chk("mid_word19_vld", ext_load_valid_o, 1'b1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", ext_load_valid_o, 1'b0);
        chk("mid_rst_addr", ext_load_addr_o, 6'd0);
        chk("mid_rst_data", ext_load_data_o, '0);
        chk("mid_rst_ready", ext_data_ready_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_overrun", overrun_o, 1'b0);
        chk("mid_rst_req_x", ext_req_x_o, 8'd0);
        tick();
        #2 rstn = 1'b1;
        tick();
        clear_mon();
        do_start(8'd3, 8'd5);
        chk("post_req_x", ext_req_x_o, 8'd3);
        ack_after2();
        feed(256, 1'b0, nr);
        finish_load();
        check_full("post", 1'b1);
`ifdef FETCH_CUR_CHROMA_LOAD_PERF_EN
        chk("post_perf", load_cycles_o, 16'd259);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
